// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response bundle between the EX-stage control and alu_multicycle
interface alu_multicycle_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ALU_start;
  logic [3:0]            ALU_control;
  logic [DATA_WIDTH-1:0] ALU_operand_1;
  logic [DATA_WIDTH-1:0] ALU_operand_2;
  logic [DATA_WIDTH-1:0] ALU_result;
  logic [DATA_WIDTH-1:0] ALU_result_hi;
  logic [7:0]            ALU_status;
  logic                  ALU_busy;
  logic                  ALU_done;

  modport master (
    output ALU_start, ALU_control, ALU_operand_1, ALU_operand_2,
    input  ALU_result, ALU_result_hi, ALU_status, ALU_busy, ALU_done
  );

  modport slave (
    input  ALU_start, ALU_control, ALU_operand_1, ALU_operand_2,
    output ALU_result, ALU_result_hi, ALU_status, ALU_busy, ALU_done
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with iterative shift-add multiply and restoring divide
// Optional ALU_SIGNED_MULDIV_EN adds signed multiply (op 11) and signed divide (op 12).
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic             clk,
  input logic             rst,
  alu_multicycle_if.slave alu_if
);
  localparam int W = DATA_WIDTH;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         res_q, res_d, res_hi_q, res_hi_d;
  logic [7:0]           status_q, status_d;
  logic [W-1:0]         acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;

  logic [3:0]   ctl;
  logic [W-1:0] op_a, op_b, mag_a, mag_b;
  logic         op_mul, op_div, mm_ovf;
  logic [W:0]   add_sum, sub_dif, mul_sum, rem_sh, rem_diff;
  logic [W-1:0] sc_res, sc_hi, it_hi, it_lo, fin_hi, fin_lo;
  logic         sc_carry, sc_ovf, sc_div0, sc_ill;

  assign ctl  = alu_if.ALU_control;
  assign op_a = alu_if.ALU_operand_1;
  assign op_b = alu_if.ALU_operand_2;

`ifdef ALU_SIGNED_MULDIV_EN
  logic op_signed;
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, mm_ovf_q, mm_ovf_d;
  assign mag_a  = (op_signed && op_a[W-1]) ? -op_a : op_a;
  assign mag_b  = (op_signed && op_b[W-1]) ? -op_b : op_b;
  assign mm_ovf = mm_ovf_q;
`else
  assign mag_a  = op_a;
  assign mag_b  = op_b;
  assign mm_ovf = 1'b0;
`endif

  always_comb begin
    op_mul = (ctl == 4'd9);
    op_div = (ctl == 4'd10);
`ifdef ALU_SIGNED_MULDIV_EN
    op_signed = 1'b0;
    if (ctl == 4'd11) begin op_mul = 1'b1; op_signed = 1'b1; end
    if (ctl == 4'd12) begin op_div = 1'b1; op_signed = 1'b1; end
`endif
  end

  // Single-cycle results; a divide only lands here when the divisor is zero.
  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_div0  = 1'b0;
    sc_ill   = 1'b0;
    add_sum  = {1'b0, op_a} + {1'b0, op_b};
    sub_dif  = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
    case (ctl)
      4'd0: sc_res = op_a & op_b;
      4'd1: sc_res = op_a | op_b;
      4'd2: begin
        sc_res   = add_sum[W-1:0];
        sc_carry = add_sum[W];
        sc_ovf   = (op_a[W-1] == op_b[W-1]) && (add_sum[W-1] != op_a[W-1]);
      end
      4'd3: sc_res = op_a ^ op_b;
      4'd4: sc_res = {{(W-1){1'b0}}, op_a == op_b};
      4'd5: sc_res = ~(op_a | op_b);
      4'd6: begin
        sc_res   = sub_dif[W-1:0];
        sc_carry = sub_dif[W];
        sc_ovf   = (op_a[W-1] != op_b[W-1]) && (sub_dif[W-1] != op_a[W-1]);
      end
      4'd7: sc_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd8: sc_res = {{(W-1){1'b0}}, op_a < op_b};
      default: begin
        if (op_div) begin
          sc_res  = '1;
          sc_hi   = op_a;
          sc_div0 = 1'b1;
        end else begin
          sc_ill  = 1'b1;
        end
      end
    endcase
  end

  // One iteration: acc_lo holds multiplier / dividend-quotient, acc_hi the partial product / remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_hi_q, acc_lo_q[W-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      it_hi = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
      it_lo = {acc_lo_q[W-2:0], ~rem_diff[W]};
    end else begin
      it_hi = mul_sum[W:1];
      it_lo = {mul_sum[0], acc_lo_q[W-1:1]};
    end
    fin_hi = it_hi;
    fin_lo = it_lo;
`ifdef ALU_SIGNED_MULDIV_EN
    if (neg_res_q) begin
      if (is_div_q) fin_lo = -it_lo;
      else          {fin_hi, fin_lo} = -{it_hi, it_lo};
    end
    if (is_div_q && neg_rem_q) fin_hi = -it_hi;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    status_d = status_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
`ifdef ALU_SIGNED_MULDIV_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mm_ovf_d  = mm_ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (alu_if.ALU_start) begin
          if (op_mul || (op_div && (op_b != '0))) begin
            state_d  = ST_ITER;
            cnt_d    = '0;
            is_div_d = op_div;
            acc_hi_d = '0;
            acc_lo_d = mag_a;
            opnd_d   = mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_res_d = op_signed && (op_a[W-1] ^ op_b[W-1]);
            neg_rem_d = op_signed && op_a[W-1];
            mm_ovf_d  = op_signed && op_div && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
`endif
          end else begin
            state_d  = ST_DONE;
            res_d    = sc_res;
            res_hi_d = sc_hi;
            status_d = {~|sc_res, sc_res[W-1], sc_carry, sc_ovf, sc_div0, sc_ill, 2'b00};
          end
        end
      end
      ST_ITER: begin
        acc_hi_d = it_hi;
        acc_lo_d = it_lo;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(W-1)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          res_d    = fin_lo;
          res_hi_d = fin_hi;
          status_d = {~|fin_lo, fin_lo[W-1], 1'b0, mm_ovf, 4'b0000};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      status_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mm_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      status_q <= status_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mm_ovf_q  <= mm_ovf_d;
`endif
    end
  end

  assign alu_if.ALU_result    = res_q;
  assign alu_if.ALU_result_hi = res_hi_q;
  assign alu_if.ALU_status    = status_q;
  assign alu_if.ALU_busy      = (state_q != ST_IDLE);
  assign alu_if.ALU_done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed and random checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.DATA_WIDTH(W)) alu_if ();

  alu_multicycle #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_if (alu_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result, high word, status and done latency (in cycles after the accept cycle) for one request.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] rh,
                                output logic [7:0] st, output int lat);
    logic   c, v, d0, il;
    int     sa, sb;
    longint s;
    logic [63:0] p;
    sa = a; sb = b;
    c = 1'b0; v = 1'b0; d0 = 1'b0; il = 1'b0;
    r = '0; rh = '0; lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        s = longint'(sa) + longint'(sb);
        v = (s != longint'(int'(s)));
      end
      4'd3: r = a ^ b;
      4'd4: r = (a == b) ? 32'd1 : 32'd0;
      4'd5: r = ~(a | b);
      4'd6: begin
        r = a - b;
        c = (a >= b);
        s = longint'(sa) - longint'(sb);
        v = (s != longint'(int'(s)));
      end
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      4'd9: begin
        p = {32'd0, a} * {32'd0, b};
        {rh, r} = p;
        lat = 33;
      end
      4'd10: begin
        if (b == 0) begin r = '1; rh = a; d0 = 1'b1; end
        else begin r = a / b; rh = a % b; lat = 33; end
      end
`ifdef ALU_SIGNED_MULDIV_EN
      4'd11: begin
        s = longint'(sa) * longint'(sb);
        {rh, r} = s;
        lat = 33;
      end
      4'd12: begin
        if (b == 0) begin r = '1; rh = a; d0 = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000; rh = 0; v = 1'b1; lat = 33;
        end else begin
          r = sa / sb; rh = sa % sb; lat = 33;
        end
      end
`endif
      default: il = 1'b1;
    endcase
    st = {r == 0, r[31], c, v, d0, il, 2'b00};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output int busy_cnt);
    @(negedge clk);
    alu_if.ALU_control   = op;
    alu_if.ALU_operand_1 = a;
    alu_if.ALU_operand_2 = b;
    alu_if.ALU_start     = 1'b1;
    @(posedge clk); #1;
    alu_if.ALU_start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!alu_if.ALU_done && cyc < 100) begin
      if (alu_if.ALU_busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (alu_if.ALU_busy) busy_cnt++;
  endtask

  task automatic check_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er, eh;
    logic [7:0]  es;
    int          el, cyc, bc;
    model(op, a, b, er, eh, es, el);
    issue(op, a, b, cyc, bc);
    chk({tag, " latency"}, cyc, el);
    chk({tag, " busy cycles"}, bc, el);
    chk({tag, " result"}, alu_if.ALU_result, er);
    chk({tag, " result_hi"}, alu_if.ALU_result_hi, eh);
    chk({tag, " status"}, alu_if.ALU_status, es);
    @(posedge clk); #1;
    chk({tag, " idle after done"}, {alu_if.ALU_busy, alu_if.ALU_done}, 2'b00);
  endtask

  initial begin
    int          ndone, dcyc, cyc, bc;
    logic [31:0] cap, a, b;
    logic [3:0]  op;

    rst = 1'b1;
    alu_if.ALU_start     = 1'b0;
    alu_if.ALU_control   = '0;
    alu_if.ALU_operand_1 = '0;
    alu_if.ALU_operand_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", alu_if.ALU_result, 0);
    chk("reset result_hi", alu_if.ALU_result_hi, 0);
    chk("reset status", alu_if.ALU_status, 0);
    chk("reset busy/done", {alu_if.ALU_busy, alu_if.ALU_done}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    check_op(4'd2, 32'h7FFF_FFFF, 32'h1, "add ovf");
    chk("add ovf const result", alu_if.ALU_result, 32'h8000_0000);
    chk("add ovf const status", alu_if.ALU_status, 8'b0101_0000);
    check_op(4'd6, 32'd5, 32'd5, "sub equal");
    chk("sub equal const status", alu_if.ALU_status, 8'b1010_0000);
    check_op(4'd7, 32'hFFFF_FFFF, 32'd1, "slt");
    chk("slt const", alu_if.ALU_result, 1);
    check_op(4'd8, 32'hFFFF_FFFF, 32'd1, "sltu");
    check_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    chk("multu const hi", alu_if.ALU_result_hi, 32'hFFFF_FFFE);
    chk("multu const lo", alu_if.ALU_result, 32'h1);
    check_op(4'd10, 32'd100, 32'd7, "divu 100/7");
    chk("divu const q/r", {alu_if.ALU_result, alu_if.ALU_result_hi}, {32'd14, 32'd2});
    check_op(4'd10, 32'd9, 32'd0, "divu by zero");
    chk("divu0 const", {alu_if.ALU_result, alu_if.ALU_result_hi, alu_if.ALU_status[3]}, {32'hFFFF_FFFF, 32'd9, 1'b1});
    check_op(4'd11, 32'hFFFF_FFFA, 32'd7, "op11 -6*7");
`ifdef ALU_SIGNED_MULDIV_EN
    chk("mult signed const", {alu_if.ALU_result_hi, alu_if.ALU_result}, 64'hFFFF_FFFF_FFFF_FFD6);
    check_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "div MIN/-1");
    chk("div MIN/-1 ovf", alu_if.ALU_status[4], 1'b1);
    check_op(4'd12, 32'hFFFF_FFF9, 32'd2, "div -7/2");
`else
    chk("op11 illegal const", {alu_if.ALU_result, alu_if.ALU_status[2]}, {32'd0, 1'b1});
`endif

    for (int i = 0; i < 16; i++) check_op(4'(i), $urandom, $urandom, "opcode sweep");

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = a;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      check_op(op, a, b, "random");
    end

    // A second start while iterating must not be queued or produce a second done.
    @(negedge clk);
    alu_if.ALU_control = 4'd9; alu_if.ALU_operand_1 = 32'd3; alu_if.ALU_operand_2 = 32'd5;
    alu_if.ALU_start = 1'b1;
    @(posedge clk); #1;
    alu_if.ALU_start = 1'b0;
    ndone = 0; dcyc = 0; cap = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        alu_if.ALU_start = 1'b1; alu_if.ALU_control = 4'd2; alu_if.ALU_operand_1 = 32'd100;
      end
      if (c == 6) alu_if.ALU_start = 1'b0;
      if (alu_if.ALU_done) begin
        ndone++;
        if (dcyc == 0) begin dcyc = c; cap = alu_if.ALU_result; end
      end
      @(posedge clk); #1;
    end
    chk("start in ITER done count", ndone, 1);
    chk("start in ITER done cycle", dcyc, 33);
    chk("start in ITER result", cap, 32'd15);

    // A start held during the DONE cycle is ignored too.
    issue(4'd2, 32'd1, 32'd2, cyc, bc);
    alu_if.ALU_start = 1'b1; alu_if.ALU_control = 4'd0;
    @(posedge clk); #1;
    alu_if.ALU_start = 1'b0;
    chk("start in DONE ignored", {alu_if.ALU_busy, alu_if.ALU_done}, 2'b00);
    chk("start in DONE result held", alu_if.ALU_result, 32'd3);

    // Reset mid-multiply aborts with everything cleared.
    @(negedge clk);
    alu_if.ALU_control = 4'd9; alu_if.ALU_operand_1 = 32'hFFFF; alu_if.ALU_operand_2 = 32'hFFFF;
    alu_if.ALU_start = 1'b1;
    @(posedge clk); #1;
    alu_if.ALU_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid reset result", {alu_if.ALU_result, alu_if.ALU_result_hi}, 64'd0);
    chk("mid reset status", alu_if.ALU_status, 0);
    chk("mid reset busy/done", {alu_if.ALU_busy, alu_if.ALU_done}, 2'b00);
    @(negedge clk);
    chk("during reset no done", alu_if.ALU_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    alu_if.ALU_control = 4'd2; alu_if.ALU_operand_1 = 32'h10; alu_if.ALU_operand_2 = 32'h20;
    alu_if.ALU_start = 1'b1;
    @(posedge clk); #1;
    alu_if.ALU_start = 1'b0;
    chk("add after reset done", alu_if.ALU_done, 1'b1);
    chk("add after reset result", alu_if.ALU_result, 32'h30);
    repeat (40) begin
      @(posedge clk); #1;
      if (alu_if.ALU_done) chk("no stray done after reset", alu_if.ALU_done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
